// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and constants for the BIST response path
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam int DATA_W    = 16;
  localparam int SIG_W     = 8;
  localparam int CNT_W     = 9;
  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/bist_signature_checker_if.sv
// rtl/bist_signature_checker_if.sv - start/busy handshake and result bundle of the signature checker
interface bist_signature_checker_if;
  import bist_pkg::*;

  logic              clr_i;
  logic              start_i;
  logic [DATA_W-1:0] data_i;
  logic              busy_o;
  logic              done_o;
  logic              pass_o;
  logic [SIG_W-1:0]  sig_o;
  logic [CNT_W-1:0]  word_cnt_o;
  logic [7:0]        pass_cnt_o;
  logic [7:0]        fail_cnt_o;

  modport master (
    output clr_i, start_i, data_i,
    input  busy_o, done_o, pass_o, sig_o, word_cnt_o, pass_cnt_o, fail_cnt_o
  );

  modport slave (
    input  clr_i, start_i, data_i,
    output busy_o, done_o, pass_o, sig_o, word_cnt_o, pass_cnt_o, fail_cnt_o
  );

endinterface

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8 register, MSB-first, load has priority over shift
module crc8_serial
  import bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY      = CRC8_POLY_DEFAULT,
  parameter logic [SIG_W-1:0] RESET_VAL = 8'h00
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             data_bit,
  output logic [SIG_W-1:0] crc
);

  logic fb;

  assign fb = crc[SIG_W-1] ^ data_bit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc <= RESET_VAL;
    end else if (load) begin
      crc <= seed;
    end else if (en) begin
      crc <= {crc[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/bist_signature_checker.sv
// rtl/bist_signature_checker.sv - folds response words into a CRC-8 signature and grades each run
module bist_signature_checker
  import bist_pkg::*;
#(
  parameter int unsigned      WORDS    = 256,
  parameter logic [SIG_W-1:0] GOLDEN   = 8'h00,
  parameter logic [SIG_W-1:0] CRC_POLY = CRC8_POLY_DEFAULT,
  parameter logic [SIG_W-1:0] CRC_INIT = 8'h00
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  bist_signature_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0]     WORDS_CNT = CNT_W'(WORDS);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = '1;

  state_e                state, state_n;
  logic [DATA_W-1:0]     sreg;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]      word_cnt, word_cnt_inc;
  logic [SIG_W-1:0]      crc;
  logic                  accept, crc_en, crc_load, word_done, check;
  logic                  done_q, pass_q;
  logic [SIG_W-1:0]      sig_q;
  logic [7:0]            pass_cnt, fail_cnt;

  assign word_cnt_inc = word_cnt + 1'b1;

  crc8_serial #(
    .POLY      (CRC_POLY),
    .RESET_VAL (CRC_INIT)
  ) u_crc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en       (crc_en),
    .load     (crc_load),
    .seed     (CRC_INIT),
    .data_bit (sreg[DATA_W-1]),
    .crc      (crc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    crc_en    = 1'b0;
    crc_load  = 1'b0;
    word_done = 1'b0;
    check     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        crc_en = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          word_done = 1'b1;
          state_n   = (word_cnt_inc == WORDS_CNT) ? CHECK : IDLE;
        end
      end
      CHECK: begin
        check    = 1'b1;
        crc_load = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Abort overrides everything, including a same-cycle start.
    if (bus.clr_i) begin
      state_n   = IDLE;
      accept    = 1'b0;
      crc_en    = 1'b0;
      word_done = 1'b0;
      check     = 1'b0;
      crc_load  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sreg    <= bus.data_i;
      bit_cnt <= '0;
    end else if (crc_en) begin
      sreg    <= {sreg[DATA_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_cnt <= '0;
    end else if (bus.clr_i || check) begin
      word_cnt <= '0;
    end else if (word_done) begin
      word_cnt <= word_cnt_inc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      sig_q    <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      done_q <= check;
      if (check) begin
        sig_q  <= crc;
        pass_q <= (crc == GOLDEN);
        if (crc == GOLDEN) begin
          if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy_o     = (state != IDLE);
  assign bus.done_o     = done_q;
  assign bus.pass_o     = pass_q;
  assign bus.sig_o      = sig_q;
  assign bus.word_cnt_o = word_cnt;
  assign bus.pass_cnt_o = pass_cnt;
  assign bus.fail_cnt_o = fail_cnt;

endmodule

// File: tb/tb_bist_signature_checker.sv
// tb/tb_bist_signature_checker.sv - scoreboard bench over four checker configurations
module tb_bist_signature_checker;
  import bist_pkg::*;

  typedef struct packed {
    logic [7:0] sig;
    logic       pass;
    logic [7:0] pcnt;
    logic [7:0] fcnt;
  } exp_t;

  function automatic int unsigned words_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 256 : 4;
  endfunction

  function automatic logic [7:0] gold_of(int i);
    return (i == 0) ? 8'h15 : (i == 1) ? 8'h03 : 8'h00;
  endfunction

  function automatic logic [7:0] crc_word(logic [7:0] c, logic [15:0] w);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int b = 15; b >= 0; b--) begin
      fb = r[7] ^ w[b];
      r  = {r[6:0], 1'b0} ^ (fb ? CRC8_POLY_DEFAULT : 8'h00);
    end
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start[4];
  logic        clr[4];
  logic [15:0] data[4];
  logic        busy[4];
  logic        done[4];
  logic        pass[4];
  logic [7:0]  sig[4];
  logic [8:0]  word_cnt[4];
  logic [7:0]  pass_cnt[4];
  logic [7:0]  fail_cnt[4];

  exp_t        exp_q[4][$];
  logic [7:0]  mdl_crc[4];
  int          mdl_words[4];
  logic [7:0]  mdl_pc[4];
  logic [7:0]  mdl_fc[4];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bist_signature_checker_if bus ();

    assign bus.start_i = start[g];
    assign bus.clr_i   = clr[g];
    assign bus.data_i  = data[g];
    assign busy[g]     = bus.busy_o;
    assign done[g]     = bus.done_o;
    assign pass[g]     = bus.pass_o;
    assign sig[g]      = bus.sig_o;
    assign word_cnt[g] = bus.word_cnt_o;
    assign pass_cnt[g] = bus.pass_cnt_o;
    assign fail_cnt[g] = bus.fail_cnt_o;

    bist_signature_checker #(
      .WORDS    (words_of(g)),
      .GOLDEN   (gold_of(g)),
      .CRC_POLY (CRC8_POLY_DEFAULT),
      .CRC_INIT (8'h00)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );

    always @(negedge clk) begin
      exp_t e;
      if (!rst && done[g]) begin
        check($sformatf("done_expected[%0d]", g), 32'(exp_q[g].size() != 0), 32'd1);
        if (exp_q[g].size() != 0) begin
          e = exp_q[g].pop_front();
          check($sformatf("sig[%0d]", g),      32'(sig[g]),      32'(e.sig));
          check($sformatf("pass[%0d]", g),     32'(pass[g]),     32'(e.pass));
          check($sformatf("pass_cnt[%0d]", g), 32'(pass_cnt[g]), 32'(e.pcnt));
          check($sformatf("fail_cnt[%0d]", g), 32'(fail_cnt[g]), 32'(e.fcnt));
          check($sformatf("busy_at_done[%0d]", g), 32'(busy[g]), 32'd0);
        end
      end
    end
  end

  task automatic mdl_reset_all();
    for (int i = 0; i < 4; i++) begin
      mdl_crc[i] = 8'h00; mdl_words[i] = 0; mdl_pc[i] = 8'h00; mdl_fc[i] = 8'h00;
      exp_q[i].delete();
    end
  endtask

  task automatic mdl_accept(input int i, input logic [15:0] w, output bit fin);
    logic p;
    mdl_crc[i] = crc_word(mdl_crc[i], w);
    mdl_words[i]++;
    fin = (mdl_words[i] == int'(words_of(i)));
    if (fin) begin
      p = (mdl_crc[i] == gold_of(i));
      if (p && mdl_pc[i] != 8'hFF) mdl_pc[i]++;
      if (!p && mdl_fc[i] != 8'hFF) mdl_fc[i]++;
      exp_q[i].push_back('{sig: mdl_crc[i], pass: p, pcnt: mdl_pc[i], fcnt: mdl_fc[i]});
      mdl_crc[i] = 8'h00;
      mdl_words[i] = 0;
    end
  endtask

  task automatic pulse(input int i, input logic [15:0] w);
    int n = 0;
    @(negedge clk);
    while (busy[i] && n < 50) begin @(negedge clk); n++; end
    check($sformatf("idle_before_start[%0d]", i), 32'(busy[i]), 32'd0);
    start[i] = 1'b1;
    data[i]  = w;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  task automatic measure(input int i, input int exp_len, input string name);
    int n = 0;
    @(negedge clk);
    while (busy[i] && n < 40) begin n++; @(negedge clk); end
    check(name, n, exp_len);
  endtask

  task automatic send(input int i, input logic [15:0] w);
    bit fin;
    pulse(i, w);
    mdl_accept(i, w, fin);
    measure(i, fin ? 17 : 16, $sformatf("busy_len[%0d]", i));
  endtask

  initial begin
    bit fin;
    for (int i = 0; i < 4; i++) begin start[i] = 0; clr[i] = 0; data[i] = 0; end
    mdl_reset_all();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("rst_busy", 32'(busy[i]), 0);
      check("rst_sig", 32'(sig[i]), 0);
      check("rst_cnts", {pass_cnt[i], fail_cnt[i], 7'd0, word_cnt[i]}, 0);
    end
    rst = 1'b0;

    send(0, 16'h0100);
    check("w1_sig", 32'(sig[0]), 32'h15);
    check("w1_pass", 32'(pass[0]), 1);
    check("w1_pass_cnt", 32'(pass_cnt[0]), 1);
    @(negedge clk);
    check("w1_done_one_cycle", 32'(done[0]), 0);

    send(0, 16'h0000);
    check("w0_sig", 32'(sig[0]), 32'h00);
    check("w0_pass", 32'(pass[0]), 0);
    check("w0_fail_cnt", 32'(fail_cnt[0]), 1);
    check("w0_pass_cnt", 32'(pass_cnt[0]), 1);

    pulse(1, 16'h0100);
    mdl_accept(1, 16'h0100, fin);
    repeat (5) @(negedge clk);
    start[1] = 1'b1; data[1] = 16'h0100;
    @(posedge clk);
    #1 start[1] = 1'b0;
    measure(1, 11, "ignored_start_busy");
    check("ignored_start_word_cnt", 32'(word_cnt[1]), 1);
    send(1, 16'h0100);
    check("w2_word_cnt", 32'(word_cnt[1]), 0);
    check("w2_sig", 32'(sig[1]), 32'h03);
    check("w2_pass", 32'(pass[1]), 1);

    for (int k = 0; k < 256; k++) send(2, 16'h0100);
    check("w256_word_cnt", 32'(word_cnt[2]), 0);

    for (int k = 0; k < 300; k++) send(0, 16'h0100);
    check("sat_pass_cnt", 32'(pass_cnt[0]), 255);
    check("sat_fail_cnt", 32'(fail_cnt[0]), 1);

    send(3, 16'h1234);
    send(3, 16'hABCD);
    send(3, 16'h0F0F);
    @(negedge clk);
    clr[3] = 1'b1; start[3] = 1'b1; data[3] = 16'hFFFF;
    @(posedge clk);
    #1 begin clr[3] = 1'b0; start[3] = 1'b0; end
    mdl_crc[3] = 8'h00; mdl_words[3] = 0;
    @(negedge clk);
    check("clr_busy", 32'(busy[3]), 0);
    check("clr_word_cnt", 32'(word_cnt[3]), 0);
    check("clr_fail_cnt_kept", 32'(fail_cnt[3]), 0);
    send(3, 16'h0100);
    send(3, 16'h0200);
    send(3, 16'h0300);
    send(3, 16'h0400);

    pulse(3, 16'hBEEF);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_async_busy", 32'(busy[3]), 0);
    check("rst_async_out", {15'd0, done[3], pass[3], sig[3], 8'd0}, 0);
    check("rst_async_cnt", {7'd0, word_cnt[3], pass_cnt[3], fail_cnt[3]}, 0);
    check("rst_async_pass_cnt0", 32'(pass_cnt[0]), 0);
    mdl_reset_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(3, 16'h0100);
    send(3, 16'h0200);
    send(3, 16'h0300);
    send(3, 16'h0400);
    send(0, 16'h0100);
    check("post_rst_sig", 32'(sig[0]), 32'h15);
    check("post_rst_pass_cnt", 32'(pass_cnt[0]), 1);

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("pending_done[%0d]", i), exp_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
